// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, lane/size fields.
// Op layout: bit3 = store, bit2 = unsigned load, bits1:0 = access size.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int OP_UNSIGNED_BIT = 2;
    localparam int OP_STORE_BIT    = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_LOAD_RD   = 3'd2,
        ST_LOAD_DATA = 3'd3,
        ST_RMW_RD    = 3'd4,
        ST_RMW_WR    = 3'd5,
        ST_ERR       = 3'd6
    } lsu_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for the load/store unit: extracts and extends load data and merges store data.
// Purely combinational; misaligned lane bits are ignored (halfword uses addr[1], word ignores both).
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;
    logic [31:0] merged;

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        sext     = !op_i[OP_UNSIGNED_BIT];

        case (op_i[1:0])
            SZ_BYTE: load_data_o = {{24{sext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_o = {{16{sext & half_sel[15]}}, half_sel};
            default: load_data_o = word_i;
        endcase

        merged = word_i;
        case (op_i[1:0])
            SZ_BYTE: merged[{addr_i, 3'b000} +: 8]      = wdata_i[7:0];
            SZ_HALF: merged[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged                             = wdata_i;
        endcase

        store_word_o = op_i[OP_STORE_BIT] ? merged : word_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide memory; sub-word stores via read-modify-write. LSU_ALIGN_CHECK_EN enables misalignment errors.
// Latency from accept: SW/error respond next cycle; loads, SB and SH respond two cycles later.
// Backpressure: req_ready only in IDLE; requester holds its request until accepted.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wr_rd,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    lsu_state_e            state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  accept;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    assign accept = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        case (req_op[1:0])
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (!op_is_legal(req_op) || misaligned) state_d = ST_ERR;
                    else if (req_op == OP_SW)                state_d = ST_WRITE;
                    else if (req_op[OP_STORE_BIT])           state_d = ST_RMW_RD;
                    else                                     state_d = ST_LOAD_RD;
                end
            end
            ST_LOAD_RD: state_d = ST_LOAD_DATA;
            ST_RMW_RD:  state_d = ST_RMW_WR;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    lsu_byte_lane u_lane (
        .op_i         (op_q),
        .addr_i       (addr_q[1:0]),
        .word_i       (mem_data_out),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    // The address follows the incoming request in IDLE so a read is always in flight at accept.
    assign req_ready   = (state_q == ST_IDLE);
    assign mem_addr    = (state_q == ST_IDLE) ? req_addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
    assign mem_wr_rd   = !((state_q == ST_WRITE) || (state_q == ST_RMW_WR));
    assign mem_data_in = (state_q == ST_WRITE)  ? wdata_q :
                         (state_q == ST_RMW_WR) ? store_word : '0;
    assign resp_valid  = (state_q == ST_WRITE) || (state_q == ST_LOAD_DATA) ||
                         (state_q == ST_RMW_WR) || (state_q == ST_ERR);
    assign resp_err    = (state_q == ST_ERR);
    assign resp_rdata  = (state_q == ST_LOAD_DATA) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-level reference model.
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic          mem_wr_rd;
    logic [31:0]   mem_data_out = '0;

    logic [31:0]   mem [0:1023];
    logic [31:0]   ref_mem [0:15];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_dat = '0;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr_rd    (mem_wr_rd),
        .mem_data_out (mem_data_out)
    );

    // Synchronous memory: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        else if (!mem_wr_rd) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = AW'(w); pre_dat = v;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[w] = v;
    endtask

    // Reference: decodes the op by table and applies the access byte by byte.
    task automatic ref_exec(input logic [3:0] op, input logic [AW+1:0] a, input logic [31:0] wd,
                            output logic [31:0] er, output logic ee, output int elat, output int ewr);
        int size, w, off, addr;
        bit is_st, sgn, legal;
        logic [63:0] v;
        logic [7:0]  b;
        addr = int'(a);
        legal = 1; is_st = 0; sgn = 0; size = 1;
        case (op)
            4'd0:  begin size = 1; sgn = 1; end
            4'd1:  begin size = 2; sgn = 1; end
            4'd2:  size = 4;
            4'd4:  size = 1;
            4'd5:  size = 2;
            4'd8:  begin size = 1; is_st = 1; end
            4'd9:  begin size = 2; is_st = 1; end
            4'd10: begin size = 4; is_st = 1; end
            default: legal = 0;
        endcase
        w = addr / 4;
        off = ((addr % 4) / size) * size;
        er = '0; ee = 1'b0; ewr = 0;
        if (!legal) ee = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        if (legal && (addr % size) != 0) ee = 1'b1;
`endif
        if (ee || op == 4'd10) elat = 1; else elat = 2;
        if (!ee && is_st) begin
            ewr = 1;
            for (int k = 0; k < size; k++) begin
                b = wd[8*k +: 8];
                ref_mem[w] = (ref_mem[w] & ~(32'hFF << (8*(off+k)))) | ({24'd0, b} << (8*(off+k)));
            end
        end else if (!ee) begin
            v = ({32'd0, ref_mem[w]} >> (8*off)) & ((64'd1 << (8*size)) - 64'd1);
            if (sgn && size < 4 && v >= (64'd1 << (8*size-1))) v = v - (64'd1 << (8*size));
            er = v[31:0];
        end
    endtask

    task automatic do_req(input logic [3:0] op, input logic [AW+1:0] a, input logic [31:0] wd);
        logic [31:0] er;
        logic        ee, got;
        int          elat, ewr, lat, wrs;
        ref_exec(op, a, wd, er, ee, elat, ewr);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        #1 chk($sformatf("ready op%h a%h", op, a), 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0; lat = 0; wrs = 0;
        last_rdata = 'x; last_err = 1'bx;
        for (int c = 1; c <= 4 && !got; c++) begin
            @(negedge clk);
            if (!mem_wr_rd) wrs++;
            if (resp_valid) begin
                got = 1'b1; lat = c; last_rdata = resp_rdata; last_err = resp_err;
            end
        end
        chk($sformatf("latency op%h a%h", op, a), 32'(lat), 32'(elat));
        chk($sformatf("rdata op%h a%h", op, a), last_rdata, er);
        chk($sformatf("err op%h a%h", op, a), 32'(last_err), 32'(ee));
        chk($sformatf("writes op%h a%h", op, a), 32'(wrs), 32'(ewr));
    endtask

    task automatic chk_word(input string tag, input int w, input logic [31:0] exp);
        @(negedge clk);
        chk(tag, mem[w], exp);
        chk({tag, "_ref"}, mem[w], ref_mem[w]);
    endtask

    task automatic abort_test(input string tag, input logic [3:0] op, input logic [AW+1:0] a, input logic [31:0] wd);
        int w;
        w = int'(a) / 4;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_wr_rd"}, 32'(mem_wr_rd), 32'd1);
        chk({tag, "_resp"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_resp_after"}, 32'(resp_valid), 32'd0);
        chk({tag, "_word"}, mem[w], ref_mem[w]);
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_wr_rd", 32'(mem_wr_rd), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", mem_data_in, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) preload(i, $urandom);

        do_req(4'b1010, 12'h010, 32'hDEADBEEF);
        do_req(4'b0010, 12'h010, 32'h0);
        chk("lw_deadbeef", last_rdata, 32'hDEADBEEF);
        chk_word("sw_word4", 4, 32'hDEADBEEF);

        preload(4, 32'h80FF7F01);
        do_req(4'b0000, 12'h010, 32'h0); chk("lb_010", last_rdata, 32'h00000001);
        do_req(4'b0000, 12'h011, 32'h0); chk("lb_011", last_rdata, 32'h0000007F);
        do_req(4'b0000, 12'h012, 32'h0); chk("lb_012", last_rdata, 32'hFFFFFFFF);
        do_req(4'b0000, 12'h013, 32'h0); chk("lb_013", last_rdata, 32'hFFFFFF80);
        do_req(4'b0100, 12'h013, 32'h0); chk("lbu_013", last_rdata, 32'h00000080);
        do_req(4'b0001, 12'h012, 32'h0); chk("lh_012", last_rdata, 32'hFFFF80FF);
        do_req(4'b0101, 12'h012, 32'h0); chk("lhu_012", last_rdata, 32'h000080FF);
        do_req(4'b0001, 12'h010, 32'h0); chk("lh_010", last_rdata, 32'h00007F01);

        preload(4, 32'h11223344);
        do_req(4'b1000, 12'h011, 32'h000000AA);
        chk_word("sb_011", 4, 32'h1122AA44);
        do_req(4'b1001, 12'h012, 32'h0000BBCC);
        chk_word("sh_012", 4, 32'hBBCCAA44);

        do_req(4'b0010, 12'h011, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("lw_011_err", 32'(last_err), 32'd1);
`else
        chk("lw_011_data", last_rdata, 32'hBBCCAA44);
`endif
        do_req(4'b1001, 12'h013, 32'h00001234);
        @(negedge clk);
        chk("sh_013_word", mem[4], ref_mem[4]);

        do_req(4'b0111, 12'h010, 32'h0);
        chk("illegal_0111", 32'(last_err), 32'd1);

        abort_test("abort_sb", 4'b1000, 12'h014, 32'h000000EE);
        abort_test("abort_sw", 4'b1010, 12'h018, 32'hCAFEF00D);

        for (int n = 0; n < 150; n++)
            do_req(4'($urandom_range(0, 15)), 12'($urandom_range(0, 63)), $urandom);

        @(negedge clk);
        for (int i = 0; i < 16; i++) chk($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
